// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter (5..8 data bits, none/odd/even parity, 1..2 stop bits)
// with a fractional baud-tick enable and a valid/ready character input.
module uart_tx_cfg #(
  parameter int BAUD_NUM  = 9,
  parameter int BAUD_DEN  = 1250,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_uart_tx
);

  localparam int         ACC_W     = $clog2(BAUD_DEN) + 1;
  localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);

  if (BAUD_NUM <= 0 || BAUD_NUM >= BAUD_DEN ||
      DATA_BITS < 5 || DATA_BITS > 8 ||
      STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY < 0 || PARITY > 2) begin : g_bad_params
    $error("uart_tx_cfg: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_sum;
  logic               tick;
  logic [7:0]         shreg;
  logic [2:0]         bit_idx;
  logic               stop_cnt;
  logic               par_bit;
  logic [7:0]         data_masked;

  assign data_masked = i_data & DATA_MASK;
  assign o_busy      = ~o_ready;

  // Phase accumulator: acc + NUM never exceeds 2*DEN, so one extra bit is enough.
  always_comb begin
    acc_sum = acc + ACC_W'(BAUD_NUM);
    tick    = (state != S_IDLE) && (acc_sum >= ACC_W'(BAUD_DEN));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      acc       <= '0;
      shreg     <= '1;
      bit_idx   <= '0;
      stop_cnt  <= 1'b0;
      par_bit   <= 1'b0;
      o_ready   <= 1'b1;
      o_done    <= 1'b0;
      o_uart_tx <= 1'b1;
    end else begin
      o_done <= 1'b0;
      if (state != S_IDLE) begin
        acc <= tick ? (acc_sum - ACC_W'(BAUD_DEN)) : acc_sum;
      end
      case (state)
        S_IDLE: begin
          if (i_valid && o_ready) begin
            state     <= S_START;
            o_ready   <= 1'b0;
            o_uart_tx <= 1'b0;
            acc       <= '0;
            shreg     <= i_data;
            par_bit   <= (PARITY == 1) ? ~(^data_masked) : (^data_masked);
          end
        end
        S_START: begin
          if (tick) begin
            state     <= S_DATA;
            bit_idx   <= '0;
            o_uart_tx <= shreg[0];
          end
        end
        S_DATA: begin
          if (tick) begin
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              if (PARITY != 0) begin
                state     <= S_PARITY;
                o_uart_tx <= par_bit;
              end else begin
                state     <= S_STOP;
                stop_cnt  <= 1'b0;
                o_uart_tx <= 1'b1;
              end
            end else begin
              shreg     <= {1'b1, shreg[7:1]};
              bit_idx   <= bit_idx + 3'd1;
              o_uart_tx <= shreg[1];
            end
          end
        end
        S_PARITY: begin
          if (tick) begin
            state     <= S_STOP;
            stop_cnt  <= 1'b0;
            o_uart_tx <= 1'b1;
          end
        end
        S_STOP: begin
          // Done fires on the closing edge so the consumer sees it together with ready.
          if (tick) begin
            if (stop_cnt == 1'(STOP_BITS - 1)) begin
              state   <= S_IDLE;
              o_ready <= 1'b1;
              o_done  <= 1'b1;
              acc     <= '0;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          o_ready   <= 1'b1;
          o_uart_tx <= 1'b1;
          acc       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: five differently configured instances, per-cycle line expectations
// queued from an independent ceil-based baud model and compared as the frame plays out.
module tb_uart_tx_cfg;

  logic       i_clk = 1'b0;
  logic       rst_n;
  logic [4:0] valid_v;
  logic [7:0] data;
  logic [4:0] ready_v, busy_v, done_v, tx_v;

  int   checks = 0;
  int   errors = 0;
  int   done_cnt0 = 0;
  logic exp_q[$];

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (done_v[0]) done_cnt0 <= done_cnt0 + 1;
  end

  uart_tx_cfg #(.BAUD_NUM(1), .BAUD_DEN(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .i_clk(i_clk), .i_rst_n(rst_n), .i_valid(valid_v[0]), .i_data(data),
    .o_ready(ready_v[0]), .o_busy(busy_v[0]), .o_done(done_v[0]), .o_uart_tx(tx_v[0]));

  uart_tx_cfg #(.BAUD_NUM(1), .BAUD_DEN(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .i_clk(i_clk), .i_rst_n(rst_n), .i_valid(valid_v[1]), .i_data(data),
    .o_ready(ready_v[1]), .o_busy(busy_v[1]), .o_done(done_v[1]), .o_uart_tx(tx_v[1]));

  uart_tx_cfg #(.BAUD_NUM(1), .BAUD_DEN(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u2 (
    .i_clk(i_clk), .i_rst_n(rst_n), .i_valid(valid_v[2]), .i_data(data),
    .o_ready(ready_v[2]), .o_busy(busy_v[2]), .o_done(done_v[2]), .o_uart_tx(tx_v[2]));

  uart_tx_cfg #(.BAUD_NUM(1), .BAUD_DEN(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u3 (
    .i_clk(i_clk), .i_rst_n(rst_n), .i_valid(valid_v[3]), .i_data(data),
    .o_ready(ready_v[3]), .o_busy(busy_v[3]), .o_done(done_v[3]), .o_uart_tx(tx_v[3]));

  uart_tx_cfg u4 (
    .i_clk(i_clk), .i_rst_n(rst_n), .i_valid(valid_v[4]), .i_data(data),
    .o_ready(ready_v[4]), .o_busy(busy_v[4]), .o_done(done_v[4]), .o_uart_tx(tx_v[4]));

  task automatic checkSignal(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic checkCount(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; leaves the bench at acceptance edge T plus 1.
  task automatic applyStimulus(input int d, input logic [7:0] b, input bit hold);
    int guard;
    guard = 0;
    while (ready_v[d] !== 1'b1 && guard < 10000) begin
      @(posedge i_clk); #1;
      guard++;
    end
    checkSignal($sformatf("ready_wait_u%0d", d), ready_v[d], 1'b1);
    data       = b;
    valid_v[d] = 1'b1;
    @(posedge i_clk); #1;
    if (!hold) valid_v[d] = 1'b0;
  endtask

  // Bit k is on the line for samples ceil(k*DEN/NUM) .. ceil((k+1)*DEN/NUM)-1 after acceptance.
  task automatic checkOutput(input int d, input logic [7:0] b, input int dbits, input int par,
                             input int stops, input int num, input int den, input string tag);
    logic       frame_bits[$];
    logic [7:0] m;
    logic       p;
    logic       e;
    int         lo, hi, j;
    m = b & 8'((1 << dbits) - 1);
    p = ^m;
    if (par == 1) p = ~p;
    frame_bits.push_back(1'b0);
    for (int i = 0; i < dbits; i++) frame_bits.push_back(b[i]);
    if (par != 0) frame_bits.push_back(p);
    for (int i = 0; i < stops; i++) frame_bits.push_back(1'b1);
    for (int k = 0; k < frame_bits.size(); k++) begin
      lo = (k * den + num - 1) / num;
      hi = ((k + 1) * den + num - 1) / num;
      for (int c = lo; c < hi; c++) exp_q.push_back(frame_bits[k]);
    end
    checkSignal({tag, "_ready_low"}, ready_v[d], 1'b0);
    checkSignal({tag, "_busy_high"}, busy_v[d], 1'b1);
    j = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkSignal($sformatf("%s_line_c%0d", tag, j), tx_v[d], e);
      if (exp_q.size() == 0) checkSignal({tag, "_done_early"}, done_v[d], 1'b0);
      @(posedge i_clk); #1;
      j++;
    end
    checkSignal({tag, "_done"}, done_v[d], 1'b1);
    checkSignal({tag, "_ready_back"}, ready_v[d], 1'b1);
    checkSignal({tag, "_busy_low"}, busy_v[d], 1'b0);
    checkSignal({tag, "_idle_line"}, tx_v[d], 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cnt_before;
    rst_n   = 1'b0;
    valid_v = '0;
    data    = '0;
    repeat (3) @(posedge i_clk);
    #1;
    for (int d = 0; d < 5; d++) begin
      checkSignal($sformatf("reset_tx_u%0d", d), tx_v[d], 1'b1);
      checkSignal($sformatf("reset_ready_u%0d", d), ready_v[d], 1'b1);
      checkSignal($sformatf("reset_busy_u%0d", d), busy_v[d], 1'b0);
      checkSignal($sformatf("reset_done_u%0d", d), done_v[d], 1'b0);
    end
    rst_n = 1'b1;
    @(posedge i_clk); #1;

    $display("[TB] 8N1 0x48");
    applyStimulus(0, 8'h48, 1'b0);
    checkOutput(0, 8'h48, 8, 0, 1, 1, 4, "n81");

    $display("[TB] 8E1 / 8O1 0x48");
    applyStimulus(1, 8'h48, 1'b0);
    checkOutput(1, 8'h48, 8, 2, 1, 1, 4, "e81");
    applyStimulus(2, 8'h48, 1'b0);
    checkOutput(2, 8'h48, 8, 1, 1, 1, 4, "o81");

    $display("[TB] 7N2 0xC1");
    applyStimulus(3, 8'hC1, 1'b0);
    checkOutput(3, 8'hC1, 7, 0, 2, 1, 4, "n72");

    $display("[TB] back-to-back with valid held");
    cnt_before = done_cnt0;
    applyStimulus(0, 8'h55, 1'b1);
    data = 8'hAA;
    checkOutput(0, 8'h55, 8, 0, 1, 1, 4, "b2b_first");
    @(posedge i_clk); #1;
    valid_v[0] = 1'b0;
    checkOutput(0, 8'hAA, 8, 0, 1, 1, 4, "b2b_second");
    repeat (10) @(posedge i_clk);
    #1;
    checkSignal("b2b_no_third_tx", tx_v[0], 1'b1);
    checkSignal("b2b_no_third_ready", ready_v[0], 1'b1);
    checkCount("b2b_done_pulses", done_cnt0 - cnt_before, 2);

    $display("[TB] default 9/1250 8N1 0x00");
    applyStimulus(4, 8'h00, 1'b0);
    checkOutput(4, 8'h00, 8, 0, 1, 9, 1250, "baud_frac");

    $display("[TB] reset mid-frame");
    applyStimulus(0, 8'h00, 1'b0);
    repeat (14) @(posedge i_clk);
    #1;
    checkSignal("rst_pre_line", tx_v[0], 1'b0);
    cnt_before = done_cnt0;
    rst_n = 1'b0;
    #1;
    checkSignal("rst_line_now", tx_v[0], 1'b1);
    checkSignal("rst_ready_now", ready_v[0], 1'b1);
    checkSignal("rst_busy_now", busy_v[0], 1'b0);
    repeat (2) @(posedge i_clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge i_clk);
    #1;
    checkSignal("rst_after_line", tx_v[0], 1'b1);
    checkSignal("rst_after_ready", ready_v[0], 1'b1);
    checkCount("rst_no_done", done_cnt0 - cnt_before, 0);
    applyStimulus(0, 8'hA5, 1'b0);
    checkOutput(0, 8'hA5, 8, 0, 1, 1, 4, "rst_new_byte");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter, next generation of the board's fixed 8N1 serial TX. It runs in the single system clock domain and uses a fractional baud-tick enable instead of a derived clock. Character width, parity and stop-bit count are configurable, and characters arrive over a valid/ready handshake. It sits between any byte producer (console FIFO, debug streamer) and the FTDI TX pin.

Parameters:
BAUD_NUM, 9, numerator of baud/clk ratio; 16 MHz / 115200 = 9/1250; must be >0 and <BAUD_DEN
BAUD_DEN, 1250, denominator of baud/clk ratio
DATA_BITS, 8, character width 5..8
PARITY, 0, 0 none / 1 odd / 2 even
STOP_BITS, 1, 1 or 2

Ports:
i_clk  in  1  system clock, all state on posedge
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  producer has a character on i_data
i_data  in  8  character, LSB first on wire; bits [7:DATA_BITS] ignored
o_ready  out  1  transmitter can accept; high only in IDLE
o_busy  out  1  frame in progress (= ~o_ready)
o_done  out  1  one-cycle pulse when the last stop bit completes
o_uart_tx  out  1  serial line, idle high

Behaviour:
- Reset (async assert, sync release): state=IDLE, o_uart_tx=1, o_ready=1, o_busy=0, o_done=0, accumulator=0, shift register=all ones. Reset mid-frame forces the line high immediately. The partial frame is dropped, not resumed.
- Handshake: accept when i_valid&&o_ready at a posedge (cycle T). Latch i_data[DATA_BITS-1:0] and compute the parity bit from the latched data at acceptance. o_ready drops at T+1. i_data is don't-care after T.
- Baud enable: accumulator width = clog2(BAUD_DEN)+1. Clear to 0 at acceptance. Each busy cycle: if acc+BAUD_NUM >= BAUD_DEN, then acc <= acc+BAUD_NUM-BAUD_DEN and tick=1; else acc <= acc+BAUD_NUM. Bit period is floor or ceil of BAUD_DEN/BAUD_NUM cycles, with no cumulative drift. The accumulator holds at 0 in IDLE.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on accept, go to START; o_uart_tx=0 from T+1.
  - START: on tick, go to DATA with bit index 0.
  - DATA: o_uart_tx = shreg[0]. On tick, shift right and increment index. After DATA_BITS bits, go to PARITY if PARITY!=0, else STOP.
  - PARITY: o_uart_tx = parity bit. Odd: total ones in data+parity is odd. Even: total is even. On tick, go to STOP.
  - STOP: o_uart_tx=1 for STOP_BITS ticks. On the final tick, go to IDLE and pulse o_done on that same edge, so o_done is high the first IDLE cycle.
- The line is registered: o_uart_tx changes only on the tick edge (or T+1 for start), so no glitches.
- Back-to-back: o_ready rises in the cycle o_done is high. If i_valid is held, the next accept happens that cycle and the next start bit appears 1 cycle after the previous stop bit ends. This effectively lengthens the stop by one clock, which is permitted.
- An i_valid held high while busy is ignored. It is not queued.
- Frame length in cycles: (1+DATA_BITS+(PARITY?1:0)+STOP_BITS) × bit period, ±1 cycle for fractional ratios.
- Illegal parameters (BAUD_NUM>=BAUD_DEN, DATA_BITS outside 5..8, STOP_BITS outside 1..2, PARITY>2) stop elaboration via a generate-time error.

Test Plan:
1. BAUD_NUM=1/DEN=4, 8N1, send 0x48 accepted at T -> line from T+1, 4 cycles each: 0, 0,0,0,1,0,0,1,0, 1. o_done high at T+41, o_ready high at T+41.
2. Same clocks, 8E1 and 8O1, send 0x48 (two ones) -> parity bit 0 for even, 1 for odd, in slot 10. The frame is 44 cycles.
3. DATA_BITS=7, STOP_BITS=2, PARITY=0, send 0xC1 -> data bits 1,0,0,0,0,0,1 (bit 7 ignored), then line high for 8 cycles. o_done at T+41.
4. i_valid held high with bytes 0x55 then 0xAA -> second start bit begins exactly 1 cycle after first stop ends. Only two accepts occur, and o_done pulses twice.
5. Default 9/1250, 8N1, send 0x00 -> every bit period is 138 or 139 cycles. Start-to-stop-end is 1388 or 1389 cycles.
6. Assert i_rst_n=0 during bit 3 of a frame -> o_uart_tx=1 in the same cycle, o_ready=1 after release, and no o_done pulse. A new byte then transmits correctly.
